// File: rtl/cr_integrity_multi.sv
// Multi-region write-integrity monitor: flags CPU/DMA writes into protected
// windows, holds the core in reset until the reset handler is fetched.
module cr_region_chk #(
  parameter logic [15:0] BASE = 16'h0160,
  parameter logic [15:0] END  = 16'h01FF
) (
  input  logic [15:0] addr_i,
  output logic        hit_o
);
  // base > end yields an empty window without special casing
  assign hit_o = (addr_i >= BASE) && (addr_i <= END);
endmodule

module cr_integrity_multi #(
  parameter int                        N_REGIONS      = 4,
  parameter logic [16*N_REGIONS-1:0]   REGION_BASE    = {N_REGIONS{16'h0160}},
  parameter logic [16*N_REGIONS-1:0]   REGION_END     = {N_REGIONS{16'h01FF}},
  parameter logic [N_REGIONS-1:0]      REGION_TRUSTED = {N_REGIONS{1'b0}},
  parameter logic [15:0]               TRUST_BASE     = 16'hE000,
  parameter logic [15:0]               TRUST_END      = 16'hE3FF,
  parameter logic [15:0]               RESET_HANDLER  = 16'h0000,
  parameter int                        MIN_RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        data_wr,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        dma_we,
  output logic        reset,
  output logic [2:0]  viol_region,
  output logic [1:0]  viol_src,
  output logic [7:0]  viol_count
);
  typedef enum logic [1:0] {RUN, HOLD, WAIT_RH} state_e;

  localparam logic [7:0] HOLD_LOAD = 8'(MIN_RST_CYCLES - 1);

  state_e         state_q, state_d;
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic           reset_q, reset_d;
  logic [2:0]     region_q, region_d;
  logic [1:0]     src_q, src_d;
  logic [7:0]     count_q, count_d;

  logic [N_REGIONS-1:0] cpu_raw, dma_raw, cpu_hit, dma_hit, any_hit;
  logic                 pc_trusted, cpu_viol, dma_viol, viol;
  logic [2:0]           low_idx;

  assign pc_trusted = (pc >= TRUST_BASE) && (pc <= TRUST_END);

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_reg
    cr_region_chk #(.BASE(REGION_BASE[16*g +: 16]), .END(REGION_END[16*g +: 16]))
      u_cpu (.addr_i(data_addr), .hit_o(cpu_raw[g]));
    cr_region_chk #(.BASE(REGION_BASE[16*g +: 16]), .END(REGION_END[16*g +: 16]))
      u_dma (.addr_i(dma_addr), .hit_o(dma_raw[g]));
    assign cpu_hit[g] = data_wr && cpu_raw[g] && !(REGION_TRUSTED[g] && pc_trusted);
    assign dma_hit[g] = dma_en && dma_we && dma_raw[g];
  end

  assign any_hit  = cpu_hit | dma_hit;
  assign cpu_viol = |cpu_hit;
  assign dma_viol = |dma_hit;
  assign viol     = cpu_viol | dma_viol;

  always_comb begin
    low_idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--)
      if (any_hit[i]) low_idx = 3'(i);
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    reset_d    = viol || (state_q != RUN);
    region_d   = region_q;
    src_d      = src_q;
    count_d    = count_q;
    if (viol) begin
      region_d = low_idx;
      src_d    = {dma_viol, cpu_viol};
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
    case (state_q)
      RUN: if (viol) begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_LOAD;
      end
      HOLD: begin
        if (viol)                   hold_cnt_d = HOLD_LOAD;
        else if (hold_cnt_q == '0)  state_d    = WAIT_RH;
        else                        hold_cnt_d = hold_cnt_q - 8'd1;
      end
      WAIT_RH: begin
        if (viol) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end else if (pc == RESET_HANDLER) begin
          state_d = RUN;
          reset_d = 1'b0;
        end
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= HOLD_LOAD;
      reset_q    <= 1'b1;
      region_q   <= '0;
      src_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      reset_q    <= reset_d;
      region_q   <= region_d;
      src_q      <= src_d;
      count_q    <= count_d;
    end
  end

  assign reset       = reset_q;
  assign viol_region = region_q;
  assign viol_src    = src_q;
  assign viol_count  = count_q;
endmodule

// File: tb/tb_cr_integrity_multi.sv
// Directed bench for cr_integrity_multi: vector table from RUN plus hand
// sequences for hold extension, handler/violation collision, reset and saturation.
module tb_cr_integrity_multi;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc, data_addr, dma_addr;
  logic        data_wr, dma_en, dma_we;
  logic        reset;
  logic [2:0]  viol_region;
  logic [1:0]  viol_src;
  logic [7:0]  viol_count;

  // r0 0160-01FF trusted, r1 0300-037F, r2 empty (base > end), r3 0150-016F
  cr_integrity_multi #(
    .N_REGIONS(4),
    .REGION_BASE({16'h0150, 16'h0400, 16'h0300, 16'h0160}),
    .REGION_END ({16'h016F, 16'h03FF, 16'h037F, 16'h01FF}),
    .REGION_TRUSTED(4'b0001),
    .TRUST_BASE(16'hE000), .TRUST_END(16'hE3FF),
    .RESET_HANDLER(16'h0000), .MIN_RST_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .data_addr(data_addr), .data_wr(data_wr),
    .dma_addr(dma_addr), .dma_en(dma_en), .dma_we(dma_we), .reset(reset),
    .viol_region(viol_region), .viol_src(viol_src), .viol_count(viol_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc, daddr;
    logic        dwr;
    logic [15:0] maddr;
    logic        men, mwe;
    logic        viol;
    logic [2:0]  rgn;
    logic [1:0]  src;
  } vec_t;

  vec_t       vecs[23];
  int         n_chk = 0, n_err = 0;
  logic [7:0] e_cnt;
  logic [2:0] e_reg;
  logic [1:0] e_src;

  function automatic vec_t mk(logic [15:0] p, logic [15:0] da, logic dw, logic [15:0] ma,
                              logic me, logic mw, logic v, logic [2:0] r, logic [1:0] s);
    vec_t t;
    t.pc = p; t.daddr = da; t.dwr = dw; t.maddr = ma; t.men = me; t.mwe = mw;
    t.viol = v; t.rgn = r; t.src = s;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [15:0] p);
    pc = p; data_addr = '0; data_wr = 0; dma_addr = '0; dma_en = 0; dma_we = 0;
  endtask

  task automatic bump;
    if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
  endtask

  task automatic chk_state(input string nm, input logic r);
    chk({nm, "_reset"}, reset, r);
    chk({nm, "_region"}, viol_region, e_reg);
    chk({nm, "_src"}, viol_src, e_src);
    chk({nm, "_count"}, viol_count, e_cnt);
  endtask

  // Handler fetched from the cycle after the violation: reset drops 5 edges later.
  task automatic recover(input string nm);
    int k;
    k = 0;
    idle(16'h0000);
    do begin
      step;
      k++;
    end while (reset && k < 20);
    chk({nm, "_hold_len"}, k, 5);
    chk({nm, "_released"}, reset, 0);
  endtask

  task automatic cpu_wr(input logic [15:0] p, input logic [15:0] a);
    idle(p);
    data_addr = a; data_wr = 1;
  endtask

  initial begin
    vecs[0]  = mk(16'h4000, 16'h0170, 1, 16'h0000, 0, 0, 1, 3'd0, 2'b01);
    vecs[1]  = mk(16'hE010, 16'h0180, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[2]  = mk(16'hE400, 16'h0180, 1, 16'h0000, 0, 0, 1, 3'd0, 2'b01);
    vecs[3]  = mk(16'hDFFF, 16'h0180, 1, 16'h0000, 0, 0, 1, 3'd0, 2'b01);
    vecs[4]  = mk(16'hE3FF, 16'h0180, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[5]  = mk(16'h4000, 16'h0161, 1, 16'h0160, 1, 1, 1, 3'd0, 2'b11);
    vecs[6]  = mk(16'h4000, 16'h0000, 0, 16'h0160, 1, 0, 0, 3'd0, 2'b00);
    vecs[7]  = mk(16'h4000, 16'h0000, 0, 16'h0160, 0, 1, 0, 3'd0, 2'b00);
    vecs[8]  = mk(16'h4000, 16'h0000, 0, 16'h0300, 1, 1, 1, 3'd1, 2'b10);
    vecs[9]  = mk(16'h4000, 16'h02FF, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[10] = mk(16'h4000, 16'h0380, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[11] = mk(16'h4000, 16'h0300, 1, 16'h0000, 0, 0, 1, 3'd1, 2'b01);
    vecs[12] = mk(16'h4000, 16'h037F, 1, 16'h0000, 0, 0, 1, 3'd1, 2'b01);
    vecs[13] = mk(16'h4000, 16'h0400, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[14] = mk(16'h4000, 16'h03FF, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[15] = mk(16'h4000, 16'h01FF, 1, 16'h0000, 0, 0, 1, 3'd0, 2'b01);
    vecs[16] = mk(16'h4000, 16'h0200, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[17] = mk(16'h4000, 16'h015F, 1, 16'h0000, 0, 0, 1, 3'd3, 2'b01);
    vecs[18] = mk(16'hE010, 16'h0165, 1, 16'h0000, 0, 0, 1, 3'd3, 2'b01);
    vecs[19] = mk(16'h4000, 16'h0300, 1, 16'h0150, 1, 1, 1, 3'd1, 2'b11);
    vecs[20] = mk(16'h4000, 16'h0170, 0, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[21] = mk(16'hE000, 16'h0180, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);
    vecs[22] = mk(16'h4000, 16'h014F, 1, 16'h0000, 0, 0, 0, 3'd0, 2'b00);

    // Power-on: reset held until the handler is fetched
    e_cnt = '0; e_reg = '0; e_src = '0;
    idle(16'h1234);
    reset_n = 0;
    step; step;
    chk_state("por", 1);
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      step;
      chk($sformatf("por_wait%0d_reset", i), reset, 1);
    end
    idle(16'h0000);
    step;
    chk("por_release_reset", reset, 0);
    chk("por_release_count", viol_count, 0);

    // Single-cycle vectors, each starting from RUN
    for (int i = 0; i < 23; i++) begin
      pc = vecs[i].pc; data_addr = vecs[i].daddr; data_wr = vecs[i].dwr;
      dma_addr = vecs[i].maddr; dma_en = vecs[i].men; dma_we = vecs[i].mwe;
      step;
      if (vecs[i].viol) begin
        bump;
        e_reg = vecs[i].rgn;
        e_src = vecs[i].src;
      end
      chk_state($sformatf("v%0d", i), vecs[i].viol);
      if (vecs[i].viol) recover($sformatf("v%0d", i));
    end

    // New violation mid-HOLD reloads the hold counter
    cpu_wr(16'h4000, 16'h0170);
    step; bump; e_reg = 3'd0; e_src = 2'b01;
    chk_state("ext_first", 1);
    idle(16'h0000);
    step; chk("ext_idle1_reset", reset, 1);
    step; chk("ext_idle2_reset", reset, 1);
    idle(16'h4000);
    dma_addr = 16'h0300; dma_en = 1; dma_we = 1;
    step; bump; e_reg = 3'd1; e_src = 2'b10;
    chk_state("ext_second", 1);
    recover("ext");

    // Violation coinciding with the handler fetch in WAIT_RH: violation wins
    cpu_wr(16'h4000, 16'h0170);
    step; bump; e_reg = 3'd0; e_src = 2'b01;
    idle(16'h1234);
    for (int i = 0; i < 5; i++) step;
    chk("wrh_waiting_reset", reset, 1);
    cpu_wr(16'h0000, 16'h0170);
    step; bump;
    chk_state("wrh_collide", 1);
    recover("wrh");

    // Synchronous reset mid-HOLD clears the record and restarts the hold
    cpu_wr(16'h4000, 16'h0300);
    step; bump; e_reg = 3'd1; e_src = 2'b01;
    chk_state("rst_viol", 1);
    idle(16'h0000);
    step;
    reset_n = 0;
    step;
    e_cnt = '0; e_reg = '0; e_src = '0;
    chk_state("rst_mid", 1);
    reset_n = 1;
    recover("rst");

    // Saturation of the violation counter
    cpu_wr(16'h4000, 16'h0170);
    for (int i = 0; i < 300; i++) begin
      step;
      bump;
    end
    e_reg = 3'd0; e_src = 2'b01;
    chk_state("sat", 1);
    chk("sat_ff", viol_count, 8'hFF);
    recover("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
